// File: rtl/lsu.sv
// Load/store unit: RISC-V lane steering and load extension in front of a handshaked word memory.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  lat_write;
    logic [2:0]            lat_funct3;
    logic [1:0]            lat_off;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            size_code;
    logic [1:0]            off_aligned;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  trap;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    // Access size: 0 = byte, 1 = half, 2 = word; unknown encodings fall back to word.
    always_comb begin
        size_code = 2'd2;
        if (req_write) begin
            if (req_funct3 == 3'b000)
                size_code = 2'd0;
            else if (req_funct3 == 3'b001)
                size_code = 2'd1;
        end else begin
            if (req_funct3 == 3'b000 || req_funct3 == 3'b100)
                size_code = 2'd0;
            else if (req_funct3 == 3'b001 || req_funct3 == 3'b101)
                size_code = 2'd1;
        end
    end

    always_comb begin
        off_aligned = req_addr[1:0];
        be_next     = 4'b1111;
        wdata_next  = req_wdata;
        case (size_code)
            2'd0: begin
                if (req_write) begin
                    be_next    = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
            end
            2'd1: begin
                off_aligned = {req_addr[1], 1'b0};
                if (req_write) begin
                    be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{req_wdata[15:0]}};
                end
            end
            default: off_aligned = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic lat_misaligned;

    assign trap = (size_code == 2'd1) ? req_addr[0] :
                  (size_code == 2'd2) ? (|req_addr[1:0]) : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lat_misaligned <= 1'b0;
        else if (state == IDLE && req_valid)
            lat_misaligned <= trap;
    end

    assign misaligned = (state == RESP) && lat_misaligned;
`else
    assign trap       = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stall      = 1'b1;
                    state_next = trap ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready)
                    state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance so the memory sees stable outputs while BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_off    <= off_aligned;
                addr_q     <= req_addr[ADDR_WIDTH+1:2];
                be_q       <= be_next;
                wdata_q    <= wdata_next;
                if (trap)
                    rdata_q <= '0;
            end
            if (state == BUSY && mem_ready)
                rdata_q <= lat_write ? '0 : ld_data;
        end
    end

    assign mem_we    = (state == BUSY) && lat_write;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-array reference memory.
module tb_lsu;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          stall;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          misaligned;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [31:0] last_rsp;
    logic [3:0]  last_be;
    logic [31:0] last_wd;
    logic [31:0] tb_mem [64];
    logic [7:0]  ref_mem [256];

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (reset && rsp_valid) pulses++;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic int sizeOf(input bit wr, input logic [2:0] f3);
        if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // One instruction: accept, BUSY with 'waits' not-ready cycles, RESP; starts and ends at a negedge.
    task automatic applyStimulus(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits, input bit hold);
        int size, base, stalls;
        bit trap;
        logic [31:0] v, erd, ewd;
        logic [3:0] ebe;
        size = sizeOf(wr, f3);
        base = int'(addr) - (int'(addr) % size);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (int'(addr) % size) != 0;
`else
        trap = 1'b0;
`endif
        v = 32'h0;
        for (int k = 0; k < size; k++) v = v | ({24'h0, ref_mem[base + k]} << (8 * k));
        if (!wr && f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (!wr && f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        erd = (wr || trap) ? 32'h0 : v;
        ebe = wr ? 4'(((1 << size) - 1) << (base % 4)) : 4'hF;
        ewd = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;

        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        #1;
        checkOutput("stall_accept", stall, 1);
        checkOutput("req_accept", mem_req, 0);
        stalls = int'(stall);
        if (!trap) begin
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                if (i == waits) begin mem_ready = 1'b1; mem_rdata = tb_mem[mem_addr]; end
                else begin mem_ready = 1'b0; mem_rdata = $urandom; end
                #1;
                checkOutput("busy_req", mem_req, 1);
                checkOutput("busy_stall", stall, 1);
                checkOutput("busy_rsp", rsp_valid, 0);
                checkOutput("busy_we", mem_we, wr);
                checkOutput("busy_addr", mem_addr, {26'h0, addr[7:2]});
                checkOutput("busy_be", mem_be, wr ? ebe : 4'hF);
                if (wr) checkOutput("busy_wdata", mem_wdata, ewd);
                stalls += int'(stall);
                last_be = mem_be; last_wd = mem_wdata;
                if (i == waits && mem_we)
                    for (int l = 0; l < 4; l++)
                        if (mem_be[l]) tb_mem[mem_addr][8*l +: 8] = mem_wdata[8*l +: 8];
            end
        end
        @(negedge clk);
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        #1;
        checkOutput("resp_valid", rsp_valid, 1);
        checkOutput("resp_stall", stall, 0);
        checkOutput("resp_req", mem_req, 0);
        checkOutput("resp_rdata", rsp_rdata, erd);
        checkOutput("resp_misaligned", misaligned, trap);
        checkOutput("stall_cycles", stalls, trap ? 1 : 2 + waits);
        last_rsp = rsp_rdata;
        exp_pulses++;
        if (wr && !trap)
            for (int k = 0; k < size; k++) ref_mem[base + k] = wdata[8*k +: 8];
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0; mem_ready = 1'b0;
            #1;
            checkOutput("idle_rsp", rsp_valid, 0);
            checkOutput("idle_stall", stall, 0);
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            tb_mem[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #2;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_misaligned", misaligned, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_be", mem_be, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        applyStimulus(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
        checkOutput("sw_be", last_be, 4'b1111);
        checkOutput("sw_wdata", last_wd, 32'hDEADBEEF);
        applyStimulus(1, 3'b010, 32'h10, 32'h80FF0000, 0, 1);
        applyStimulus(0, 3'b000, 32'h13, 32'h0, 0, 1);
        checkOutput("lb_sign", last_rsp, 32'hFFFFFF80);
        applyStimulus(0, 3'b100, 32'h13, 32'h0, 1, 0);
        checkOutput("lbu_zero", last_rsp, 32'h00000080);
        applyStimulus(1, 3'b010, 32'h04, 32'h7FFF1234, 0, 0);
        applyStimulus(0, 3'b001, 32'h06, 32'h0, 0, 0);
        checkOutput("lh_upper", last_rsp, 32'h00007FFF);
        applyStimulus(1, 3'b001, 32'h06, 32'h0000ABCD, 2, 0);
        checkOutput("sh_be", last_be, 4'b1100);
        checkOutput("sh_wdata", last_wd, 32'hABCDABCD);
        applyStimulus(0, 3'b010, 32'h20, 32'h0, 3, 0);
        applyStimulus(0, 3'b010, 32'h02, 32'h0, 0, 0);

        // Abandon a store mid-BUSY; the word must stay untouched.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h24; req_wdata = 32'h12345678; mem_ready = 1'b0;
        @(negedge clk); #1;
        checkOutput("abort_req_up", mem_req, 1);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        checkOutput("abort_req_drop", mem_req, 0);
        checkOutput("abort_stall", stall, 0);
        checkOutput("abort_we", mem_we, 0);
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checkOutput("abort_no_rsp", rsp_valid, 0);
        end
        applyStimulus(0, 3'b010, 32'h24, 32'h0, 0, 0);

        for (int n = 0; n < 150; n++)
            applyStimulus(1'($urandom), 3'($urandom), {24'h0, 8'($urandom)}, $urandom,
                          int'($urandom_range(0, 3)), 1'($urandom));
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        checkOutput("rsp_pulses", pulses, exp_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core datapath and a handshaked data memory; it replaces the direct single-cycle `data_mem` hookup. It accepts one load or store per instruction, performs RISC-V byte/halfword/word lane steering and load sign/zero extension, and stalls the core until the memory acknowledges the access. Its output `rsp_rdata` is the `WB_MEM` writeback source.

## Interface
- `DATA_WIDTH`, 32, data path width; only 32 is supported.
- `ADDR_WIDTH`, `ADDR_WIDTH` from defines, width of the word address to memory.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: the current instruction is a load or store (`mem_read | mem_write`).
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: hold PC and suppress regfile write while high.
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `rsp_rdata` out 32: extended load data; 0 after stores.
- `misaligned` out 1: one-cycle pulse for a rejected misaligned access (see Configuration).
- `mem_req` out 1: memory request; held until accepted.
- `mem_we` out 1: write enable.
- `mem_addr` out `ADDR_WIDTH`: word address, `req_addr[ADDR_WIDTH+1:2]`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-steered store data.
- `mem_ready` in 1: memory accepts the request (writes) or returns data (reads) this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high.

## Operation
- FSM has three states: IDLE, BUSY, RESP. Reset puts it in IDLE.
- IDLE: when `req_valid` is high, latch write flag, funct3, `addr[1:0]`, word address, byte enables and steered wdata, then go to BUSY.
- BUSY: `mem_req` = 1 and all `mem_*` outputs stay stable. On a cycle with `mem_ready` high, capture the extended read data (loads) or 0 (stores), then go to RESP.
- RESP: `rsp_valid` = 1, then go to IDLE. `req_valid` is ignored in RESP, because the same instruction is still presented.
- `stall` = (IDLE & `req_valid`) | BUSY. `stall` is low in RESP, so the core retires the instruction and writes back `rsp_rdata` in that cycle.
- Store steering:
  - SB: `be = 1 << addr[1:0]`; byte replicated to all 4 lanes.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`; half replicated to both lanes.
  - SW: `be = 4'b1111`.
- Loads:
  - `mem_be = 4'b1111`.
  - Select byte/half by the latched offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Unsupported funct3 encodings behave as LW/SW.

## Timing
- Reset values: `stall`, `rsp_valid`, `misaligned`, `mem_req`, `mem_we` = 0; `mem_be` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0.
- `mem_req` is registered: it rises the cycle after IDLE accepts the request.
- Zero-wait memory (`mem_ready` high in the first BUSY cycle):
  - Per access: 1 accept cycle + 1 BUSY cycle + 1 RESP cycle.
  - The core sees 2 stall cycles per access.
- Each extra cycle with `mem_ready` low adds one BUSY cycle.
- `mem_ready` outside BUSY is ignored.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle after RESP.
- Reset asserted mid-access: `mem_req` drops asynchronously and the FSM returns to IDLE. No `rsp_valid` is produced, and any pending write is abandoned.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- When defined:
  - LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` ≠ 0, issues no memory request.
  - FSM goes IDLE → RESP directly (`stall` high 1 cycle), with `misaligned` = 1 and `rsp_valid` = 1 in RESP and `rsp_rdata` = 0.
- When undefined:
  - `misaligned` is tied 0.
  - Offset bits below the access size are ignored (address aligned down); the access proceeds normally.

## Test plan
- SW addr 0x10, data 0xDEADBEEF, zero-wait memory → `mem_addr` = 4, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF; `stall` high 2 cycles; `rsp_valid` in cycle 3.
- LB addr 0x13 with `mem_rdata` = 0x80FF_0000 → `rsp_rdata` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr 0x06, data 0x0000ABCD → `mem_be` = 1100, `mem_wdata` = 0xABCDABCD. LH at 0x06 with `mem_rdata` = 0x7FFF1234 → `rsp_rdata` = 0x00007FFF.
- LW with `mem_ready` low for 3 BUSY cycles → `mem_req`/`mem_addr` stable throughout; `stall` high 5 cycles; `rsp_valid` exactly once.
- Reset pulled low during BUSY → `mem_req` = 0 immediately; after release, state is IDLE, no `rsp_valid`, and the next request is accepted normally.
- LW addr 0x02:
  - With `LSU_MISALIGN_TRAP_EN` → no `mem_req`; `misaligned` and `rsp_valid` pulse together.
  - Without it → word at 0x00 is read.
